// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encoding, sequencer
// state and default latencies. Also imported by the decoder and hazard unit.
package mdu_pkg;

    localparam logic [1:0] MDU_NONE = 2'b00;
    localparam logic [1:0] MDU_MUL  = 2'b01;
    localparam logic [1:0] MDU_DIV  = 2'b10;
    localparam logic [1:0] MDU_REM  = 2'b11;

    localparam int MUL_LAT_DEFAULT = 3;
    localparam int DIV_LAT_DEFAULT = 33;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } mdu_state_e;

    // DIV and REM share the divider datapath and its latency.
    function automatic logic is_div_op(input logic [1:0] op);
        return (op == MDU_DIV) || (op == MDU_REM);
    endfunction

endpackage

// File: rtl/mdu_sequencer_lat_counter.sv
// Loadable down-counter timing an in-flight MDU op; flags the last RUN cycle.
module lat_counter #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         is_one
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign is_one = (cnt == W'(1));

endmodule

// File: rtl/mdu_sequencer.sv
// Holds an MDU instruction in EXE for the op's latency, stalling the front of
// the pipe and bubbling EX/MEM, and releases it once the result is ready.
module mdu_sequencer
    import mdu_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEFAULT,
    parameter int DIV_LAT = DIV_LAT_DEFAULT,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mdu_req_EXE,
    input  logic [1:0]       mdu_op_EXE,
    input  logic             divisor_zero_EXE,
    input  logic             kill_EXE,
    input  logic             ex_hold,
    output logic             mdu_start,
    output logic             mdu_abort,
    output logic             stall_mdu,
    output logic             result_valid,
    output logic             busy,
    output logic [CNT_W-1:0] busy_cycles
);

    localparam int CW = $clog2(DIV_LAT);

    mdu_state_e    state;
    logic          go;
    logic          div_op;
    logic          zero_shortcut;
    logic          cnt_load;
    logic          cnt_dec;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_load_val;
    logic          cnt_is_one;

    assign go            = (state == IDLE) && mdu_req_EXE && (mdu_op_EXE != MDU_NONE) && !kill_EXE;
    assign div_op        = is_div_op(mdu_op_EXE);
    assign zero_shortcut = div_op && divisor_zero_EXE;
    assign cnt_load      = go && !zero_shortcut;
    assign cnt_load_val  = div_op ? CW'(DIV_LAT - 1) : CW'(MUL_LAT - 1);
    assign cnt_dec       = (state == RUN) && !kill_EXE && !cnt_is_one;

    lat_counter #(.W(CW)) u_lat_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .cnt      (cnt),
        .is_one   (cnt_is_one)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (go) state <= zero_shortcut ? DONE : RUN;
                RUN: begin
                    if (kill_EXE)        state <= IDLE;
                    else if (cnt_is_one) state <= DONE;
                end
                DONE: if (!(ex_hold && !kill_EXE)) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Result handshake: result_valid offers the result to EXE; ex_hold is the
    // inverse of ready. The result is consumed in a cycle with result_valid=1
    // and ex_hold=0; while held, the sequencer keeps stalling and stays in DONE.
    always_comb begin
        mdu_start    = 1'b0;
        mdu_abort    = 1'b0;
        stall_mdu    = 1'b0;
        result_valid = 1'b0;
        case (state)
            IDLE: begin
                mdu_start = go;
                stall_mdu = go;
            end
            RUN: begin
                stall_mdu = 1'b1;
                mdu_abort = kill_EXE;
            end
            DONE: begin
                result_valid = !kill_EXE;
                stall_mdu    = ex_hold && !kill_EXE;
            end
            default: ;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_cycles <= '0;
        end else if (stall_mdu) begin
            busy_cycles <= busy_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Scenario bench for mdu_sequencer: expected per-cycle output vectors queued
// at drive time and checked mid-cycle, plus busy-cycle counter checks.
module tb_mdu_sequencer;
    import mdu_pkg::*;

    localparam int CNT_W = 4;

    // Output vector layout: {mdu_start, mdu_abort, stall_mdu, result_valid, busy}
    localparam logic [4:0] V_IDLE  = 5'b00000;
    localparam logic [4:0] V_GO    = 5'b10100;
    localparam logic [4:0] V_RUN   = 5'b00101;
    localparam logic [4:0] V_DONE  = 5'b00011;
    localparam logic [4:0] V_HOLD  = 5'b00111;
    localparam logic [4:0] V_ABORT = 5'b01101;
    localparam logic [4:0] V_DKILL = 5'b00001;

    logic             clk = 1'b0;
    logic             rst;
    logic             mdu_req_EXE;
    logic [1:0]       mdu_op_EXE;
    logic             divisor_zero_EXE;
    logic             kill_EXE;
    logic             ex_hold;
    logic             mdu_start;
    logic             mdu_abort;
    logic             stall_mdu;
    logic             result_valid;
    logic             busy;
    logic [CNT_W-1:0] busy_cycles;

    logic [4:0]       exp_q[$];
    logic [CNT_W-1:0] exp_busy;
    logic [CNT_W-1:0] busy_now;
    int               n_vec;
    int               n_err;

    mdu_sequencer #(.MUL_LAT(3), .DIV_LAT(33), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .mdu_req_EXE      (mdu_req_EXE),
        .mdu_op_EXE       (mdu_op_EXE),
        .divisor_zero_EXE (divisor_zero_EXE),
        .kill_EXE         (kill_EXE),
        .ex_hold          (ex_hold),
        .mdu_start        (mdu_start),
        .mdu_abort        (mdu_abort),
        .stall_mdu        (stall_mdu),
        .result_valid     (result_valid),
        .busy             (busy),
        .busy_cycles      (busy_cycles)
    );

    always #5 clk = ~clk;

    // One cycle: drive inputs after the edge, queue the expected outputs and
    // counter, then pop and compare mid-cycle.
    task automatic drive(input logic r, input logic req, input logic [1:0] op,
                         input logic dz, input logic kill, input logic hold,
                         input logic [4:0] exp, input string name);
        logic [4:0] e;
        logic [4:0] obs;
        @(posedge clk);
        #1;
        rst              = r;
        mdu_req_EXE      = req;
        mdu_op_EXE       = op;
        divisor_zero_EXE = dz;
        kill_EXE         = kill;
        ex_hold          = hold;
        exp_q.push_back(exp);
        busy_now = exp_busy;
        if (r)           exp_busy = '0;
        else if (exp[2]) exp_busy = exp_busy + 1'b1;
        @(negedge clk);
        e   = exp_q.pop_front();
        obs = {mdu_start, mdu_abort, stall_mdu, result_valid, busy};
        n_vec++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL %s: {start,abort,stall,valid,busy} got %b expected %b", name, obs, e);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; mdu_req_EXE = 1'b0; mdu_op_EXE = MDU_NONE;
        divisor_zero_EXE = 1'b0; kill_EXE = 1'b0; ex_hold = 1'b0;
        exp_busy = '0;
        repeat (2) @(posedge clk);
        drive(0, 0, MDU_NONE, 0, 0, 0, V_IDLE, "reset_outputs");
        n_vec++;
        if (busy_cycles !== '0) begin
            n_err++;
            $display("FAIL reset_busy_cycles: got %0d expected 0", busy_cycles);
        end
    endtask

    task automatic test_mul();
        drive(0, 1, MDU_MUL, 0, 0, 0, V_GO,   "mul_c0");
        drive(0, 1, MDU_MUL, 0, 0, 0, V_RUN,  "mul_c1");
        drive(0, 1, MDU_MUL, 0, 0, 0, V_RUN,  "mul_c2");
        drive(0, 1, MDU_MUL, 0, 0, 0, V_DONE, "mul_c3");
        drive(0, 0, MDU_NONE, 0, 0, 0, V_IDLE, "mul_c4");
        n_vec++;
        if (busy_cycles !== 4'd3) begin
            n_err++;
            $display("FAIL mul_busy_cycles: got %0d expected 3", busy_cycles);
        end
    endtask

    task automatic test_div();
        drive(0, 1, MDU_DIV, 0, 0, 0, V_GO, "div_c0");
        for (int i = 1; i < 33; i++) drive(0, 1, MDU_DIV, 0, 0, 0, V_RUN, "div_run");
        drive(0, 1, MDU_DIV, 0, 0, 0, V_DONE, "div_c33");
        drive(0, 0, MDU_NONE, 0, 0, 0, V_IDLE, "div_c34");
        // 3 + 33 stall cycles = 36, which wraps a 4-bit counter to 4
        n_vec++;
        if (busy_cycles !== busy_now || busy_cycles !== 4'd4) begin
            n_err++;
            $display("FAIL div_busy_wrap: got %0d expected %0d", busy_cycles, busy_now);
        end
    endtask

    task automatic test_div_zero();
        drive(0, 1, MDU_DIV, 1, 0, 0, V_GO,   "divz_c0");
        drive(0, 1, MDU_DIV, 1, 0, 0, V_DONE, "divz_c1");
        drive(0, 0, MDU_NONE, 0, 0, 0, V_IDLE, "divz_c2");
        drive(0, 1, MDU_REM, 1, 0, 0, V_GO,   "remz_c0");
        drive(0, 1, MDU_REM, 1, 0, 0, V_DONE, "remz_c1");
        drive(0, 0, MDU_NONE, 0, 0, 0, V_IDLE, "remz_c2");
        // a zero divisor on MUL does not shortcut
        drive(0, 1, MDU_MUL, 1, 0, 0, V_GO,   "mulz_c0");
        drive(0, 1, MDU_MUL, 1, 0, 0, V_RUN,  "mulz_c1");
        drive(0, 1, MDU_MUL, 1, 0, 0, V_RUN,  "mulz_c2");
        drive(0, 1, MDU_MUL, 1, 0, 0, V_DONE, "mulz_c3");
        drive(0, 0, MDU_NONE, 0, 0, 0, V_IDLE, "mulz_c4");
    endtask

    task automatic test_kill();
        drive(0, 1, MDU_MUL, 0, 0, 0, V_GO,    "kill_c0");
        drive(0, 1, MDU_MUL, 0, 1, 0, V_ABORT, "kill_c1");
        drive(0, 0, MDU_NONE, 0, 0, 0, V_IDLE, "kill_c2");
        drive(0, 1, MDU_MUL, 0, 1, 0, V_IDLE,  "kill_at_go");
        drive(0, 0, MDU_NONE, 0, 0, 0, V_IDLE, "kill_at_go_next");
        drive(0, 1, MDU_NONE, 0, 0, 0, V_IDLE, "op_none_req");
    endtask

    task automatic test_hold();
        int n;
        drive(0, 1, MDU_MUL, 0, 0, 0, V_GO,  "hold_c0");
        drive(0, 1, MDU_MUL, 0, 0, 0, V_RUN, "hold_c1");
        drive(0, 1, MDU_MUL, 0, 0, 0, V_RUN, "hold_c2");
        drive(0, 1, MDU_MUL, 0, 0, 1, V_HOLD, "hold_done1");
        drive(0, 1, MDU_MUL, 0, 0, 1, V_HOLD, "hold_done2");
        drive(0, 1, MDU_MUL, 0, 0, 0, V_DONE, "hold_release");
        drive(0, 0, MDU_NONE, 0, 0, 0, V_IDLE, "hold_idle");
        // random hold length, then kill while held: kill wins, no abort
        n = $urandom_range(1, 4);
        drive(0, 1, MDU_MUL, 0, 0, 0, V_GO,  "khold_c0");
        drive(0, 1, MDU_MUL, 0, 0, 0, V_RUN, "khold_c1");
        drive(0, 1, MDU_MUL, 0, 0, 0, V_RUN, "khold_c2");
        for (int i = 0; i < n; i++) drive(0, 1, MDU_MUL, 0, 0, 1, V_HOLD, "khold_held");
        drive(0, 1, MDU_MUL, 0, 1, 1, V_DKILL, "khold_kill");
        drive(0, 0, MDU_NONE, 0, 0, 0, V_IDLE, "khold_idle");
        n_vec++;
        if (busy_cycles !== busy_now) begin
            n_err++;
            $display("FAIL hold_busy_cycles: got %0d expected %0d", busy_cycles, busy_now);
        end
    endtask

    task automatic test_back_to_back();
        drive(0, 1, MDU_MUL, 0, 0, 0, V_GO,   "b2b_a0");
        drive(0, 1, MDU_MUL, 0, 0, 0, V_RUN,  "b2b_a1");
        drive(0, 1, MDU_MUL, 0, 0, 0, V_RUN,  "b2b_a2");
        drive(0, 1, MDU_MUL, 0, 0, 0, V_DONE, "b2b_a3");
        drive(0, 1, MDU_MUL, 0, 0, 0, V_GO,   "b2b_b0");
        drive(0, 1, MDU_MUL, 0, 0, 0, V_RUN,  "b2b_b1");
        drive(0, 1, MDU_MUL, 0, 0, 0, V_RUN,  "b2b_b2");
        drive(0, 1, MDU_MUL, 0, 0, 0, V_DONE, "b2b_b3");
        drive(0, 1, MDU_MUL, 0, 0, 0, V_GO,   "b2b_c0");
        drive(1, 1, MDU_MUL, 0, 0, 0, V_RUN,  "b2b_rst_in_run");
        drive(0, 0, MDU_NONE, 0, 0, 0, V_IDLE, "b2b_after_rst");
        n_vec++;
        if (busy_cycles !== '0) begin
            n_err++;
            $display("FAIL b2b_busy_after_rst: got %0d expected 0", busy_cycles);
        end
    endtask

    task automatic test_idle_noise();
        for (int i = 0; i < 8; i++)
            drive(0, 1'($urandom_range(0, 1)), MDU_NONE, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), V_IDLE, "idle_noise");
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_mul();
        test_div();
        test_div_zero();
        test_kill();
        test_hold();
        test_idle_noise();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mdu_sequencer.md
# mdu_sequencer

Sequences the multi-cycle multiply/divide unit (MDU) in the EXE stage of the 5-stage pipeline. It pulses the MDU start and holds the MDU instruction in EXE for the op's latency. During that time it freezes PC/IF/ID/EXE and injects bubbles into EX/MEM. It releases the instruction when the result is ready. Its stall output is ORed into the hazard-stall network alongside the load-use stall.

## Interface
- `MUL_LAT`, 3, cycles from start to result for MUL; must be ≥2.
- `DIV_LAT`, 33, cycles from start to result for DIV/REM; must be ≥2.
- `CNT_W`, 32, width of busy-cycle performance counter.
- `clk`  in  1  pipeline clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `mdu_req_EXE`  in  1  DE register holds a valid MDU instruction.
- `mdu_op_EXE`  in  2  op: 00 none, 01 MUL, 10 DIV, 11 REM.
- `divisor_zero_EXE`  in  1  rs2 operand in EXE is zero.
- `kill_EXE`  in  1  discard the EXE instruction (exception/redirect).
- `ex_hold`  in  1  downstream cannot accept EXE's output this cycle.
- `mdu_start`  out  1  one-cycle start pulse to the MDU.
- `mdu_abort`  out  1  one-cycle pulse: the in-flight op was cancelled.
- `stall_mdu`  out  1  hold PC, FD, DE; flush EM (bubble).
- `result_valid`  out  1  MDU result valid; EXE may advance.
- `busy`  out  1  state ≠ IDLE.
- `busy_cycles`  out  CNT_W  count of cycles with `stall_mdu`=1; wraps.

## Operation
- FSM states: IDLE, RUN, DONE. A down-counter `cnt` has width clog2(DIV_LAT).
- **IDLE**, when `mdu_req_EXE` and op≠00 and ~`kill_EXE` ("go"):
  - `mdu_start`=1 and `stall_mdu`=1; latch op.
  - DIV/REM with `divisor_zero_EXE`: next state DONE (shortcut).
  - Otherwise: load `cnt`=LAT−1 for the op, next state RUN.
- **IDLE**, no go: all outputs 0.
- **RUN**:
  - `stall_mdu`=1.
  - `kill_EXE`: `mdu_abort`=1, next state IDLE.
  - Else if `cnt`==1: next state DONE.
  - Else: decrement `cnt`.
- **DONE**:
  - `result_valid` = ~`kill_EXE`; `stall_mdu` = `ex_hold` & ~`kill_EXE`.
  - Stay in DONE while `ex_hold` & ~`kill_EXE`; otherwise next state IDLE.
  - `kill_EXE` in DONE returns to IDLE with no abort pulse; the result is simply discarded.
- Op 00 with req high is ignored: no start, no stall.
- The DONE→IDLE transition coincides with EXE advancing. Any req seen in IDLE afterwards is therefore a new instruction, and back-to-back MDU ops start with no extra gap cycle.
- `busy_cycles` increments every cycle `stall_mdu`=1 and wraps modulo 2^CNT_W.

## Timing
- Reset: state IDLE, `cnt`=0, `busy_cycles`=0. All outputs are 0 in the cycle after reset.
- Reset mid-operation: next cycle is IDLE with no `result_valid` and no `mdu_abort`.
- All control outputs are combinational from state plus inputs, and valid in the same cycle.
- Normal op, go in cycle 0:
  - `stall_mdu`=1 in cycles 0…LAT−1 (LAT cycles).
  - `result_valid`=1 in cycle LAT, extended while `ex_hold`.
- Divide-by-zero shortcut: stall only in cycle 0; `result_valid` in cycle 1.
- Kill and `ex_hold` together in DONE: kill wins.
- Kill in the same cycle as go: no start, no stall.

## Structure
- Shared package `mdu_pkg` holds:
  - op encoding constants (MDU_NONE/MUL/DIV/REM);
  - the state enum (IDLE/RUN/DONE);
  - default latency constants.
- The hazard unit and the decoder import `mdu_pkg` for the op field.
- One sub-module is natural: `lat_counter`, a loadable down-counter with a `cnt`==1 flag.
- `busy_cycles` stays inline.

## Test plan
- **MUL, MUL_LAT=3**: req with op=01 in cycle 0.
  - `mdu_start` in cycle 0 only; `stall_mdu` in cycles 0–2.
  - `result_valid` in cycle 3; `busy_cycles`=3.
- **DIV, DIV_LAT=33**: `stall_mdu` for exactly 33 cycles, then `result_valid` for 1 cycle.
- **DIV with `divisor_zero_EXE`=1**: stall in cycle 0 only; `result_valid` in cycle 1.
- **MUL followed by kill**: go in cycle 0, `kill_EXE` in cycle 1.
  - `mdu_abort` in cycle 1; IDLE in cycle 2; no `result_valid`.
- **Hold in DONE**: `ex_hold`=1 for 2 cycles in DONE.
  - `result_valid` and `stall_mdu` high for those 2 cycles, then IDLE.
- **Back-to-back MULs plus reset**: two MULs back to back; second `mdu_start` occurs the cycle after the first `result_valid`. Then assert `rst` in RUN: next cycle all outputs 0 and `busy_cycles`=0.
